regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file; successor to the 2R/1W regfile.
//   N read ports, M write ports, optional write-to-read bypass, per-register busy scoreboard.
//   Sequential clear after reset (one entry per cycle, SRAM-friendly).
//   Sits in decode/writeback of the multi-issue core; drives operands and hazard stall inputs.
// PARAMETERS
//   XLEN      32  data width (riscv_pkg default)
//   NUM_REGS  32  register count; AW = $clog2(NUM_REGS)
//   NUM_RD    2   read ports, >=1
//   NUM_WR    1   write ports, >=1; higher index = higher priority
//   BYPASS    1   1: same-cycle write data forwarded to reads; 0: reads return stored value
// PORTS
//   clk          in   1              clock, all state updates on posedge
//   rst_n        in   1              asynchronous reset, active-low
//   rd_addr      in   NUM_RD*AW      read addresses, port i at [i*AW +: AW]
//   rd_data      out  NUM_RD*XLEN    read data, combinational
//   rd_busy      out  NUM_RD         scoreboard bit of addressed register, combinational
//   wr_en        in   NUM_WR         write enables
//   wr_addr      in   NUM_WR*AW      write addresses
//   wr_data      in   NUM_WR*XLEN    write data
//   sb_set_en    in   1              mark sb_set_addr busy (instruction issued)
//   sb_set_addr  in   AW             register to mark busy
//   init_done    out  1              1 once the clear sequence has completed
//   wr_collide   out  1              registered pulse: >=2 enabled writes hit same non-x0 address
// BEHAVIOUR
//   Reset (rst_n=0, async): FSM->INIT, clr_cnt=0, busy[*]=0, init_done=0, wr_collide=0.
//   Register contents are not reset asynchronously.
//   FSM INIT: each posedge writes registers[clr_cnt]=0, clr_cnt++.
//   INIT -> READY on the posedge writing entry NUM_REGS-1 (NUM_REGS cycles after release).
//   In INIT: wr_en and sb_set_en ignored; rd_data=0, rd_busy=0.
//   READY: absorbing until rst_n asserted. rst_n low mid-INIT restarts clear from 0.
//   Write: for each port j with wr_en[j] and wr_addr[j]!=0, registers[wr_addr[j]] <= wr_data[j] at posedge.
//   Same-address write conflict: highest-index enabled port wins.
//   wr_collide=1 for exactly the cycle after the conflict.
//   x0: writes dropped, never bypassed, never busy; rd_data=0 for address 0.
//   Read: rd_data[i] = registers[rd_addr[i]] (0-cycle latency).
//   BYPASS=1: an enabled, non-x0 write to the same address overrides the stored value.
//   Bypass source follows the same priority rule (highest-index matching port wins).
//   Scoreboard: busy[r] set at posedge when sb_set_en and sb_set_addr=r (r!=0).
//   busy[r] clears at posedge when any enabled write port targets r.
//   Set and clear of the same r in one cycle: set wins (new producer issued).
//   sb_set_addr=0 ignored.
//   rd_busy[i] = busy[rd_addr[i]]; it does not see the same-cycle clear.
//   Consumers read data via bypass, and the stall decision uses the registered busy bit.
//   Out-of-range addresses (NUM_REGS not a power of 2): writes dropped, reads return 0, busy 0.
// TESTING
//   1 Reset release: init_done=0 for 32 cycles, then 1; all regs read 0 via every port; rd_busy=0.
//   2 x0: wr_en[0]=1, addr 0, data 0x12345678 -> rd_data(x0)=0; sb_set x0 -> rd_busy=0.
//   3 Bypass (BYPASS=1): x10 holds 0x12345678; write 0x11111111 to x10 -> rd_data(x10)=0x11111111 same cycle.
//     BYPASS=0 build: same stimulus reads 0x12345678 until the posedge.
//   4 Collision (NUM_WR=2): port0 x5=0xAAAA_AAAA, port1 x5=0xBBBB_BBBB -> x5=0xBBBBBBBB, wr_collide=1 for one cycle.
//   5 Scoreboard: sb_set x7 -> rd_busy=1 next cycle.
//     Write x7=0x77 with sb_set x7 in same cycle -> busy stays 1.
//     Write again with sb_set_en=0 -> busy=0, x7=0x77.
//   6 Reset mid-INIT: drop rst_n at clr_cnt=12 -> init_done=0, busy cleared; after release full 32-cycle clear, then 1.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, busy scoreboard and sequential post-reset clear.
// Latency: reads are combinational (0 cycles); writes, busy updates and wr_collide take effect at the next posedge.
// Backpressure: none. Writes and scoreboard sets are ignored until o_init_done is 1, which takes NUM_REGS cycles after reset.
//
// Ports:
//   i_clk, i_rst_n        clock; asynchronous active-low reset
//   i_rd_addr/o_rd_data   NUM_RD read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   o_rd_busy             registered scoreboard bit of each addressed register
//   i_wr_en/addr/data     NUM_WR write ports; the highest enabled index wins on the same address
//   i_sb_set_en/addr      marks a register busy when an instruction that produces it issues
//   o_init_done           high once the clear sequence has finished
//   o_wr_collide          one-cycle pulse after two or more enabled writes hit the same non-x0 register
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_RD*AW-1:0]   i_rd_addr,
    output logic [NUM_RD*XLEN-1:0] o_rd_data,
    output logic [NUM_RD-1:0]      o_rd_busy,
    input  logic [NUM_WR-1:0]      i_wr_en,
    input  logic [NUM_WR*AW-1:0]   i_wr_addr,
    input  logic [NUM_WR*XLEN-1:0] i_wr_data,
    input  logic                   i_sb_set_en,
    input  logic [AW-1:0]          i_sb_set_addr,
    output logic                   o_init_done,
    output logic                   o_wr_collide
);

    // One extra bit so NUM_REGS itself is representable in the range check.
    localparam logic [AW:0]   LP_NREGS = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LP_LAST  = AW'(NUM_REGS - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_clr_cnt;
    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_wr_collide;

    logic                w_ready;
    logic [AW-1:0]       w_rd_a [NUM_RD];
    logic [AW-1:0]       w_wr_a [NUM_WR];
    logic [XLEN-1:0]     w_wr_d [NUM_WR];
    logic [NUM_WR-1:0]   w_wr_ok;
    logic [NUM_REGS-1:0] w_busy_clr;
    logic [NUM_REGS-1:0] w_busy_set;
    logic                w_collide;

    // x0 and out-of-range addresses never hold state.
    function automatic logic f_addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < LP_NREGS);
    endfunction

    genvar g;
    for (g = 0; g < NUM_RD; g++) begin : g_rd
        assign w_rd_a[g] = i_rd_addr[g*AW +: AW];
    end
    for (g = 0; g < NUM_WR; g++) begin : g_wr
        assign w_wr_a[g] = i_wr_addr[g*AW +: AW];
        assign w_wr_d[g] = i_wr_data[g*XLEN +: XLEN];
    end

    // FSM state register; the clear counter advances only while clearing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_clr_cnt <= r_clr_cnt + AW'(1);
            end
        end
    end

    // FSM next state: leave INIT on the edge that clears the last entry.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_clr_cnt == LP_LAST) begin
            w_state_nxt = ST_READY;
        end
    end

    // FSM outputs.
    always_comb begin
        w_ready = (r_state == ST_READY);
    end

    assign o_init_done  = w_ready;
    assign o_wr_collide = r_wr_collide;

    // Write-port qualification, scoreboard masks and collision detect.
    always_comb begin
        w_wr_ok    = '0;
        w_busy_clr = '0;
        w_busy_set = '0;
        w_collide  = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_ok[j] = w_ready && i_wr_en[j] && f_addr_ok(w_wr_a[j]);
            if (w_wr_ok[j]) begin
                w_busy_clr[w_wr_a[j]] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (w_wr_ok[j] && w_wr_ok[k] && w_wr_a[j] == w_wr_a[k]) begin
                    w_collide = 1'b1;
                end
            end
        end
        if (w_ready && i_sb_set_en && f_addr_ok(i_sb_set_addr)) begin
            w_busy_set[i_sb_set_addr] = 1'b1;
        end
    end

    // Storage has no reset: it is zeroed one entry per cycle in INIT.
    // Ascending port loop lets the highest-index port win the last assignment.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) begin
            r_regs[r_clr_cnt] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_regs[w_wr_a[j]] <= w_wr_d[j];
                end
            end
        end
    end

    // Set is applied after clear so a newly issued producer keeps the register busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy       <= '0;
            r_wr_collide <= 1'b0;
        end else begin
            r_busy       <= (r_busy & ~w_busy_clr) | w_busy_set;
            r_wr_collide <= w_collide;
        end
    end

    // Read ports. rd_busy uses the registered bit so a same-cycle writeback still stalls;
    // the consumer picks up that data through the bypass instead.
    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_ready && f_addr_ok(w_rd_a[i])) begin
                o_rd_data[i*XLEN +: XLEN] = r_regs[w_rd_a[i]];
                o_rd_busy[i]              = r_busy[w_rd_a[i]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (w_wr_ok[j] && w_wr_a[j] == w_rd_a[i]) begin
                            o_rd_data[i*XLEN +: XLEN] = w_wr_d[j];
                        end
                    end
                end
            end
        end
    end

endmodule
